// File: rtl/alu_pkg.sv
// Shared constants for the ALU: opcode encodings and the hex seven-segment glyph table.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  // Segment bits are {g,f,e,d,c,b,a}, active-high; entry n is the glyph for hex digit n.
  localparam logic [6:0] SEG7_CODES [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/alu_hex_to_seg7.sv
// Purely combinational hex nibble to seven-segment glyph decoder.
module hex_to_seg7
  import alu_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Glyph lookup; every nibble value has an entry, so no fallback is needed.
  always_comb begin
    seg = SEG7_CODES[nibble];
  end

endmodule

// File: rtl/alu.sv
// Add/sub/AND/XOR ALU with a zero-on-subtract flag, plus a registered result,
// status and hex seven-segment image for the display path.
module alu
  import alu_pkg::*;
#(
  parameter  int WIDTH  = 4,
  localparam int DIGITS = (WIDTH + 3) / 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  input  logic [1:0]            op_code,
  output logic [WIDTH-1:0]      result,
  output logic                  status,
  output logic [WIDTH-1:0]      result_q,
  output logic                  status_q,
  output logic [7*DIGITS-1:0]   seg
);

  logic [WIDTH-1:0]    result_d;
  logic                status_d;
  logic [4*DIGITS-1:0] result_pad_s;
  logic [7*DIGITS-1:0] seg_d;
  logic [7*DIGITS-1:0] seg_q;

  // Operation select; add and subtract wrap modulo 2^WIDTH.
  always_comb begin
    result_d = '0;
    case (op_code)
      OP_ADD:  result_d = a + b;
      OP_SUB:  result_d = a - b;
      OP_AND:  result_d = a & b;
      OP_XOR:  result_d = a ^ b;
      default: result_d = '0;
    endcase
  end

  // Zero flag is only meaningful for subtract (equality compare use).
  always_comb begin
    if (op_code == OP_SUB) begin
      status_d = (result_d == '0);
    end else begin
      status_d = 1'b0;
    end
  end

  // Zero-extend the result to whole nibbles so the top digit decodes cleanly.
  always_comb begin
    result_pad_s              = '0;
    result_pad_s[WIDTH-1:0]   = result_d;
  end

  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    hex_to_seg7 u_hex_to_seg7 (
      .nibble (result_pad_s[4*d +: 4]),
      .seg    (seg_d[7*d +: 7])
    );
  end

  // Display-path output stage; captures every cycle, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      status_q <= 1'b0;
      seg_q    <= '0;
    end else begin
      result_q <= result_d;
      status_q <= status_d;
      seg_q    <= seg_d;
    end
  end

  assign result = result_d;
  assign status = status_d;
  assign seg    = seg_q;

endmodule

// File: tb/tb_alu.sv
// Directed and exhaustive checks of the ALU combinational path and its registered display stage.
module tb_alu;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic [1:0] op_code;
  logic [3:0] result;
  logic       status;
  logic [3:0] result_q;
  logic       status_q;
  logic [6:0] seg;

  int checks;
  int errors;

  typedef struct {
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] exp_result;
    logic       exp_status;
    string      name;
  } vec_t;

  vec_t vecs [8];

  alu #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .op_code  (op_code),
    .result   (result),
    .status   (status),
    .result_q (result_q),
    .status_q (status_q),
    .seg      (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic [3:0] m_res;
    logic       m_st;

    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    a       = 4'd0;
    b       = 4'd0;
    op_code = 2'b00;

    vecs[0] = '{2'b00, 4'd6,    4'd10,   4'd0,    1'b0, "add_wrap"};
    vecs[1] = '{2'b01, 4'd3,    4'd10,   4'd9,    1'b0, "sub_wrap"};
    vecs[2] = '{2'b01, 4'd1,    4'd1,    4'd0,    1'b1, "sub_zero"};
    vecs[3] = '{2'b00, 4'd0,    4'd0,    4'd0,    1'b0, "add_zero"};
    vecs[4] = '{2'b10, 4'b0100, 4'b1101, 4'b0100, 1'b0, "and"};
    vecs[5] = '{2'b11, 4'b0100, 4'b1101, 4'b1001, 1'b0, "xor"};
    vecs[6] = '{2'b10, 4'b0101, 4'b1010, 4'd0,    1'b0, "and_zero"};
    vecs[7] = '{2'b11, 4'd7,    4'd7,    4'd0,    1'b0, "xor_zero"};

    #1;
    check("reset_result_q", 32'(result_q), 32'h0);
    check("reset_status_q", 32'(status_q), 32'h0);
    check("reset_seg",      32'(seg),      32'h0);

    for (int i = 0; i < 8; i++) begin
      op_code = vecs[i].op;
      a       = vecs[i].a;
      b       = vecs[i].b;
      #5;
      check({vecs[i].name, "_result"}, 32'(result), 32'(vecs[i].exp_result));
      check({vecs[i].name, "_status"}, 32'(status), 32'(vecs[i].exp_status));
    end

    // Exhaustive combinational sweep against a reference model
    for (int op = 0; op < 4; op++) begin
      for (int ia = 0; ia < 16; ia++) begin
        for (int ib = 0; ib < 16; ib++) begin
          op_code = 2'(op);
          a       = 4'(ia);
          b       = 4'(ib);
          #5;
          case (op)
            0:       m_res = 4'((ia + ib) % 16);
            1:       m_res = 4'((ia - ib + 16) % 16);
            2:       m_res = 4'(ia & ib);
            default: m_res = 4'(ia ^ ib);
          endcase
          m_st = (op == 1) && (m_res == 4'd0);
          if (result !== m_res || status !== m_st) begin
            $display("FAIL sweep op=%0d a=%0d b=%0d: got result=%0h status=%0b expected result=%0h status=%0b",
                     op, ia, ib, result, status, m_res, m_st);
            errors++;
          end
          checks++;
        end
      end
    end

    // Registered path
    @(negedge clk);
    rst     = 1'b0;
    op_code = 2'b01;
    a       = 4'd10;
    b       = 4'd3;
    #1;
    check("reg_comb_result", 32'(result),   32'h7);
    check("reg_pre_edge_q",  32'(result_q), 32'h0);
    @(posedge clk);
    #1;
    check("reg_result_q", 32'(result_q), 32'h7);
    check("reg_status_q", 32'(status_q), 32'h0);
    check("reg_seg_7",    32'(seg),      32'h07);

    @(negedge clk);
    op_code = 2'b00;
    a       = 4'd15;
    b       = 4'd0;
    #1;
    check("reg_hold_seg", 32'(seg), 32'h07);
    @(posedge clk);
    #1;
    check("reg_seg_f",      32'(seg),      32'h71);
    check("reg_result_q_f", 32'(result_q), 32'hF);

    @(negedge clk);
    op_code = 2'b01;
    a       = 4'd1;
    b       = 4'd1;
    @(posedge clk);
    #1;
    check("reg_status_q_zero", 32'(status_q), 32'h1);
    check("reg_seg_0",         32'(seg),      32'h3F);

    @(negedge clk);
    op_code = 2'b01;
    a       = 4'd10;
    b       = 4'd3;
    @(posedge clk);
    #1;
    check("pre_rst_result_q", 32'(result_q), 32'h7);

    // Async reset between edges
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_result_q", 32'(result_q), 32'h0);
    check("arst_status_q", 32'(status_q), 32'h0);
    check("arst_seg",      32'(seg),      32'h0);
    check("arst_comb",     32'(result),   32'h7);
    @(posedge clk);
    #1;
    check("arst_held_q", 32'(result_q), 32'h0);

    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_no_edge_q", 32'(result_q), 32'h0);
    @(posedge clk);
    #1;
    check("rel_result_q", 32'(result_q), 32'h7);
    check("rel_seg",      32'(seg),      32'h07);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
